uart_debug_bridge: RTL and testbench

Parametrised UART debug bridge. It parses CRC-protected command packets from a byte-level UART receiver and turns them into bus writes, address loads, error clears and, optionally, bus reads. Read data goes back to the host as CRC-protected response packets on a byte-level UART transmitter. It sits between the board UART byte engines and the system debug bus, and adds configurable bus width and an inter-byte timeout.

---
 rtl/uart_debug_bridge.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_debug_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_bridge.sv
// rtl/uart_debug_bridge.sv - UART debug bridge: CRC-8 command packets to debug bus, optional read responses
//
// Purpose:
//   Parses packets from a byte-level UART receiver:
//     0xCD, cmd, DBYTES data bytes (LSB first), crc
//   The CRC is CRC-8 (poly 0x07, init 0, MSB-first), covers 0xCD through the crc byte,
//   and the packet is good when the running CRC ends at 0x00.
//   cmd 0x00 = write, 0x01 = load address, 0x02 = clear error, 0x03 = read.
//   Read data goes back as 0xDC, DBYTES data bytes (LSB first), crc. The crc covers
//   0xDC and the data, so the host sees a running CRC of 0 at the end.
//
// Optional feature macro:
//   DEBUG_READ_EN - builds cmd 0x03, the RDWAIT/TX states and the tx outputs.
//                   When it is not defined, sys_rd/tx_valid/tx_data are tied low and
//                   sys_rdata/sys_rvalid/tx_busy are not used.
//
// Ports:
//   sys_clk, sys_rst_n     clock, synchronous active-low reset
//   rx_data, rx_ready      received byte and its one-cycle strobe
//   tx_data, tx_valid      byte to transmit, held until accepted (tx_valid & !tx_busy)
//   tx_busy                transmitter cannot accept a byte
//   sys_wr, sys_rd         one-cycle bus write / read strobes
//   sys_addr, sys_wdata    bus address and write data
//   sys_rdata, sys_rvalid  read data and its strobe
//   error                  sticky error flag
//   crc_ok                 last CRC result seen was zero

module uart_debug_bridge #(
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              sys_wr,
    output logic              sys_rd,
    output logic [AWIDTH-1:0] sys_addr,
    output logic [DWIDTH-1:0] sys_wdata,
    input  logic [DWIDTH-1:0] sys_rdata,
    input  logic              sys_rvalid,
    output logic              error,
    output logic              crc_ok
);

    localparam int DBYTES = DWIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DAT,
        ST_CRC,
        ST_RDWAIT,
        ST_TX
    } state_t;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction

    state_t              r_state;
    logic [7:0]          r_crc;
    logic                r_crc_ok;
    logic                r_error;
    logic [7:0]          r_cmd;
    logic [2:0]          r_idx;
    logic [DWIDTH-1:0]   r_data;
    logic [DWIDTH-1:0]   r_wdata;
    logic [AWIDTH-1:0]   r_addr;
    logic                r_wr;
    logic [31:0]         r_tmo_cnt;

    logic [7:0]          w_crc_next;
    logic [AWIDTH-1:0]   w_load_addr;
    logic                w_in_pkt;
    logic                w_tmo_hit;

    assign w_crc_next = crc8_byte(r_crc, rx_data);
    assign w_in_pkt   = (r_state == ST_CMD) || (r_state == ST_DAT) || (r_state == ST_CRC);

    // Expiry only counts when no byte arrives this cycle: a byte always wins.
    assign w_tmo_hit  = (TIMEOUT != 0) && w_in_pkt && !rx_ready &&
                        (r_tmo_cnt == 32'(TIMEOUT - 1));

    // Load-address data is truncated or zero-extended to AWIDTH.
    genvar gi;
    generate
        for (gi = 0; gi < AWIDTH; gi++) begin : g_load_addr
            if (gi < DWIDTH) begin : g_bit
                assign w_load_addr[gi] = r_data[gi];
            end else begin : g_zero
                assign w_load_addr[gi] = 1'b0;
            end
        end
    endgenerate

    assign sys_wr    = r_wr;
    assign sys_addr  = r_addr;
    assign sys_wdata = r_wdata;
    assign error     = r_error;
    assign crc_ok    = r_crc_ok;

`ifdef DEBUG_READ_EN
    logic                r_rd;
    logic                r_tx_valid;
    logic [7:0]          r_tx_data;
    logic [7:0]          r_rcrc;
    logic [DWIDTH-1:0]   r_rdata;
    logic [2:0]          r_tx_idx;

    // Response CRC includes the 0xDC header so the host's running CRC ends at 0.
    function automatic logic [7:0] crc_resp(input logic [DWIDTH-1:0] d);
        logic [7:0] c;
        c = crc8_byte(8'h00, 8'hDC);
        for (int i = 0; i < DBYTES; i++) begin
            c = crc8_byte(c, d[i*8 +: 8]);
        end
        return c;
    endfunction

    assign sys_rd   = r_rd;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{sys_rdata, sys_rvalid, tx_busy};
    assign sys_rd   = 1'b0;
    assign tx_valid = 1'b0;
    assign tx_data  = 8'h00;
`endif

    // Inter-byte timeout counter: restarts on every byte, runs only inside a packet.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (rx_ready || !w_in_pkt || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state  <= ST_IDLE;
            r_crc    <= 8'h00;
            r_crc_ok <= 1'b1;
            r_error  <= 1'b0;
            r_cmd    <= 8'h00;
            r_idx    <= '0;
            r_data   <= '0;
            r_wdata  <= '0;
            r_addr   <= '0;
            r_wr     <= 1'b0;
`ifdef DEBUG_READ_EN
            r_rd       <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_rcrc     <= 8'h00;
            r_rdata    <= '0;
            r_tx_idx   <= '0;
`endif
        end else begin
            r_wr <= 1'b0;
`ifdef DEBUG_READ_EN
            r_rd <= 1'b0;
`endif
            // Post-write increment lands the cycle after the strobe.
            if (r_wr) begin
                r_addr <= r_addr + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_crc <= 8'h00;
                    if (rx_ready) begin
                        if (rx_data == 8'hCD) begin
                            r_crc    <= w_crc_next;
                            r_crc_ok <= (w_crc_next == 8'h00);
                            r_state  <= ST_CMD;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end

                ST_CMD: begin
                    if (rx_ready) begin
                        r_cmd    <= rx_data;
                        r_crc    <= w_crc_next;
                        r_crc_ok <= (w_crc_next == 8'h00);
                        r_idx    <= '0;
                        r_state  <= ST_DAT;
                    end
                end

                ST_DAT: begin
                    if (rx_ready) begin
                        r_data[int'(r_idx)*8 +: 8] <= rx_data;
                        r_crc    <= w_crc_next;
                        r_crc_ok <= (w_crc_next == 8'h00);
                        if (r_idx == 3'(DBYTES - 1)) begin
                            r_state <= ST_CRC;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end

                ST_CRC: begin
                    if (rx_ready) begin
                        r_crc    <= 8'h00;
                        r_crc_ok <= (w_crc_next == 8'h00);
                        r_state  <= ST_IDLE;
                        if (w_crc_next != 8'h00) begin
                            r_error <= 1'b1;
                        end else begin
                            case (r_cmd)
                                8'h00: begin
                                    r_wr    <= 1'b1;
                                    r_wdata <= r_data;
                                end
                                8'h01: r_addr  <= w_load_addr;
                                8'h02: r_error <= 1'b0;
`ifdef DEBUG_READ_EN
                                8'h03: begin
                                    r_rd    <= 1'b1;
                                    r_state <= ST_RDWAIT;
                                end
`endif
                                default: r_error <= 1'b1;
                            endcase
                        end
                    end
                end

`ifdef DEBUG_READ_EN
                ST_RDWAIT: begin
                    if (rx_ready) begin
                        r_error <= 1'b1;
                    end
                    if (sys_rvalid) begin
                        r_rdata    <= sys_rdata;
                        r_rcrc     <= crc_resp(sys_rdata);
                        r_addr     <= r_addr + 1'b1;
                        r_tx_data  <= 8'hDC;
                        r_tx_valid <= 1'b1;
                        r_tx_idx   <= '0;
                        r_state    <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (rx_ready) begin
                        r_error <= 1'b1;
                    end
                    // r_tx_idx is the byte on the wire: 0 header, 1..DBYTES data, DBYTES+1 crc.
                    if (r_tx_valid && !tx_busy) begin
                        if (r_tx_idx == 3'(DBYTES + 1)) begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_tx_idx <= r_tx_idx + 3'd1;
                            if (r_tx_idx == 3'(DBYTES)) begin
                                r_tx_data <= r_rcrc;
                            end else begin
                                r_tx_data <= r_rdata[int'(r_tx_idx)*8 +: 8];
                            end
                        end
                    end
                end
`endif

                default: r_state <= ST_IDLE;
            endcase

            if (w_tmo_hit) begin
                r_state  <= ST_IDLE;
                r_crc    <= 8'h00;
                r_crc_ok <= 1'b1;
                r_error  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_debug_bridge.sv
// tb/tb_uart_debug_bridge.sv - self-checking bench for uart_debug_bridge
module tb_uart_debug_bridge;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 100;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_ready = 1'b0;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_busy = 1'b0;
    logic           sys_wr;
    logic           sys_rd;
    logic [AW-1:0]  sys_addr;
    logic [DW-1:0]  sys_wdata;
    logic [DW-1:0]  sys_rdata = '0;
    logic           sys_rvalid = 1'b0;
    logic           error;
    logic           crc_ok;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] txq[$];
    logic       tx_seen = 1'b0;
    logic       wr_prev = 1'b0;

    uart_debug_bridge #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_busy    (tx_busy),
        .sys_wr     (sys_wr),
        .sys_rd     (sys_rd),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_rdata  (sys_rdata),
        .sys_rvalid (sys_rvalid),
        .error      (error),
        .crc_ok     (crc_ok)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input logic [15:0] d, input bit bad,
                            input bit exp_wr, input bit exp_rd, input logic [15:0] exp_addr);
        logic [7:0] c;
        c = crc8(8'h00, 8'hCD);
        c = crc8(c, cmd);
        c = crc8(c, d[7:0]);
        c = crc8(c, d[15:8]);
        if (bad) c = c ^ 8'h5A;
        if (exp_wr) sb.push_back('{exp_addr, d});
        send_byte(8'hCD);  tick(1);
        send_byte(cmd);    tick(1);
        send_byte(d[7:0]); tick(1);
        send_byte(d[15:8]); tick(1);
        send_byte(c);
        check("wr_strobe", 32'(sys_wr), 32'(exp_wr));
        check("rd_strobe", 32'(sys_rd), 32'(exp_rd));
        tick(2);
    endtask

    // Write scoreboard: every sys_wr pulse must match the oldest queued write and last one cycle.
    always @(negedge sys_clk) begin
        wr_t e;
        if (tx_valid) tx_seen = 1'b1;
        if (sys_wr) begin
            checks++;
            assert (sb.size() > 0 && !wr_prev) else begin
                errors++;
                $error("FAIL wr_unexpected: observed addr 0x%0h queued %0d prev %0b expected queued>0 prev 0",
                       sys_addr, sb.size(), wr_prev);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert ({sys_addr, sys_wdata} === {e.a, e.d}) else begin
                    errors++;
                    $error("FAIL wr_data: observed 0x%0h/0x%0h expected 0x%0h/0x%0h",
                           sys_addr, sys_wdata, e.a, e.d);
                end
            end
        end
        wr_prev = sys_wr;
    end

    initial begin
`ifdef DEBUG_READ_EN
        logic [7:0] rc;
        logic [7:0] exp_b;
`endif
        sys_rst_n = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        tick(1);
        check("rst_error",    32'(error),     32'h0);
        check("rst_crc_ok",   32'(crc_ok),    32'h1);
        check("rst_wr",       32'(sys_wr),    32'h0);
        check("rst_rd",       32'(sys_rd),    32'h0);
        check("rst_tx_valid", 32'(tx_valid),  32'h0);
        check("rst_tx_data",  32'(tx_data),   32'h0);
        check("rst_addr",     32'(sys_addr),  32'h0);
        check("rst_wdata",    32'(sys_wdata), 32'h0);

        // Set address then write.
        send_pkt(8'h01, 16'h1234, 0, 0, 0, 16'h0);
        check("setaddr", 32'(sys_addr), 32'h1234);
        send_pkt(8'h00, 16'hBEEF, 0, 1, 0, 16'h1234);
        check("addr_inc",  32'(sys_addr), 32'h1235);
        check("good_err",  32'(error),    32'h0);
        check("good_crc",  32'(crc_ok),   32'h1);

        // Bad CRC: no write, error set; then error clear.
        send_pkt(8'h00, 16'hBEEF, 1, 0, 0, 16'h0);
        check("bad_err",   32'(error),    32'h1);
        check("bad_crc",   32'(crc_ok),   32'h0);
        check("bad_addr",  32'(sys_addr), 32'h1235);
        send_pkt(8'h02, 16'h0000, 0, 0, 0, 16'h0);
        check("clr_err",   32'(error),    32'h0);

        // Inter-byte timeout after CD 00.
        send_byte(8'hCD); tick(1);
        send_byte(8'h00);
        tick(90);
        check("tmo_early", 32'(error), 32'h0);
        tick(15);
        check("tmo_err",   32'(error), 32'h1);
        send_pkt(8'h00, 16'hCAFE, 0, 1, 0, 16'h1235);
        check("tmo_recover", 32'(sys_addr), 32'h1236);
        send_pkt(8'h02, 16'h0000, 0, 0, 0, 16'h0);

        // Address wrap.
        send_pkt(8'h01, 16'hFFFF, 0, 0, 0, 16'h0);
        send_pkt(8'h00, 16'h1111, 0, 1, 0, 16'hFFFF);
        send_pkt(8'h00, 16'h2222, 0, 1, 0, 16'h0000);
        check("wrap_addr", 32'(sys_addr), 32'h0001);

`ifdef DEBUG_READ_EN
        // Read: response DC 5A A5 crc with a slow transmitter.
        rc = crc8(8'h00, 8'hDC);
        rc = crc8(rc, 8'h5A);
        rc = crc8(rc, 8'hA5);
        txq.push_back(8'hDC); txq.push_back(8'h5A); txq.push_back(8'hA5); txq.push_back(rc);
        tx_busy = 1'b1;
        send_pkt(8'h03, 16'h0000, 0, 0, 1, 16'h0);
        tick(2);
        sys_rvalid = 1'b1;
        sys_rdata  = 16'hA55A;
        tick(1);
        sys_rvalid = 1'b0;
        sys_rdata  = '0;
        check("rd_first_valid", 32'(tx_valid), 32'h1);
        rc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tx_busy = 1'b1;
            tick(3);
            exp_b = txq.pop_front();
            check("tx_valid_hold", 32'(tx_valid), 32'h1);
            check("tx_byte",       32'(tx_data),  32'(exp_b));
            rc = crc8(rc, tx_data);
            tx_busy = 1'b0;
            tick(1);
        end
        tx_busy = 1'b0;
        check("tx_done",  32'(tx_valid), 32'h0);
        check("tx_crc0",  32'(rc),       32'h0);
        check("rd_addr",  32'(sys_addr), 32'h0002);
        check("rd_err",   32'(error),    32'h0);
`else
        // Read command is unknown without the read build.
        send_pkt(8'h03, 16'h0000, 0, 0, 0, 16'h0);
        check("rd_unknown_err", 32'(error), 32'h1);
        tick(20);
        check("no_tx_valid", 32'(tx_seen),  32'h0);
        check("rd_no_addr",  32'(sys_addr), 32'h0001);
        send_pkt(8'h02, 16'h0000, 0, 0, 0, 16'h0);
`endif

        // Sync: stray byte in IDLE.
        check("pre_sync_err", 32'(error), 32'h0);
        send_byte(8'h00);
        tick(1);
        check("sync_err", 32'(error), 32'h1);

        // Reset mid-packet.
        send_pkt(8'h01, 16'h0042, 0, 0, 0, 16'h0);
        check("pre_rst_addr", 32'(sys_addr), 32'h0042);
        send_byte(8'hCD); tick(1);
        send_byte(8'h00);
        sys_rst_n = 1'b0;
        tick(1);
        sys_rst_n = 1'b1;
        check("mid_rst_addr",  32'(sys_addr),  32'h0);
        check("mid_rst_wdata", 32'(sys_wdata), 32'h0);
        check("mid_rst_err",   32'(error),     32'h0);
        check("mid_rst_crc",   32'(crc_ok),    32'h1);
        check("mid_rst_wr",    32'(sys_wr),    32'h0);
        send_byte(8'hEF); tick(1);
        send_byte(8'hBE); tick(1);
        send_byte(8'h00);
        tick(4);
        check("post_rst_err", 32'(error), 32'h1);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
